// File: rtl/vram_port_b_writer_if.sv
// rtl/vram_port_b_writer_if.sv - request, fill-command and RAM port B signals of the VRAM port B writer
interface vram_port_b_writer_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW-1:0] fill_len;
  logic [DW-1:0] fill_data;
  logic          fill_done;
  logic          fill_rej;
  logic          busy;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dinb;
  logic          enb;
  logic          web;

  modport master (
    output wr_valid, wr_addr, wr_data, fill_start, fill_base, fill_len, fill_data,
    input  wr_ready, fill_done, fill_rej, busy, addrb, dinb, enb, web
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, fill_start, fill_base, fill_len, fill_data,
    output wr_ready, fill_done, fill_rej, busy, addrb, dinb, enb, web
  );
endinterface

// File: rtl/vram_port_b_writer.sv
// rtl/vram_port_b_writer.sv - sole writer of VRAM port B: request FIFO drain plus range fill engine
// Fill engine and FILL state are built only when VRAM_FILL_EN is defined.
module vram_port_b_writer #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clkb,
  input  logic               rst_n,
  vram_port_b_writer_if.slave bus
);

  localparam int             PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]    PTR_ONE  = 1;
  localparam logic [AW-1:0]  ADDR_ONE = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_FILL} state_t;

  state_t        r_state;
  logic [AW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW:0]   r_wptr;
  logic [PW:0]   r_rptr;
  logic [AW-1:0] r_addrb;
  logic [DW-1:0] r_dinb;
  logic          r_enb;
  logic          r_fill_done;
  logic          r_fill_rej;

  logic          w_empty;
  logic          w_full;
  logic          w_one;
  logic          w_push;
  logic          w_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_one   = ((r_wptr - r_rptr) == PTR_ONE);
  assign w_push  = bus.wr_valid && !w_full;
  assign w_pop   = (r_state == ST_DRAIN) && !w_empty;

  assign bus.wr_ready = !w_full;
  assign bus.busy     = (r_state != ST_IDLE) || !w_empty;
  assign bus.addrb    = r_addrb;
  assign bus.dinb     = r_dinb;
  assign bus.enb      = r_enb;
  assign bus.web      = r_enb;

`ifdef VRAM_FILL_EN
  logic [AW-1:0] r_fill_addr;
  logic [AW-1:0] r_fill_left;
  logic [DW-1:0] r_fill_data;

  assign bus.fill_done = r_fill_done;
  assign bus.fill_rej  = r_fill_rej;
`else
  logic w_unused_fill;

  assign w_unused_fill = ^{bus.fill_start, bus.fill_base, bus.fill_len, bus.fill_data,
                           r_fill_done, r_fill_rej};
  assign bus.fill_done = 1'b0;
  assign bus.fill_rej  = 1'b0;
`endif

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clkb) begin
    if (w_push) begin
      r_fifo_addr[r_wptr[PW-1:0]] <= bus.wr_addr;
      r_fifo_data[r_wptr[PW-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_addrb     <= '0;
      r_dinb      <= '0;
      r_enb       <= 1'b0;
      r_fill_done <= 1'b0;
      r_fill_rej  <= 1'b0;
`ifdef VRAM_FILL_EN
      r_fill_addr <= '0;
      r_fill_left <= '0;
      r_fill_data <= '0;
`endif
    end else begin
      r_enb       <= 1'b0;
      r_fill_done <= 1'b0;
      r_fill_rej  <= 1'b0;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;

      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_DRAIN;
`ifdef VRAM_FILL_EN
          if (bus.fill_start) begin
            if (w_empty) begin
              r_state     <= ST_FILL;
              r_fill_addr <= bus.fill_base;
              r_fill_left <= bus.fill_len;
              r_fill_data <= bus.fill_data;
            end else begin
              r_fill_rej  <= 1'b1;
            end
          end
`endif
        end

        ST_DRAIN: begin
          if (!w_empty) begin
            r_enb   <= 1'b1;
            r_addrb <= r_fifo_addr[r_rptr[PW-1:0]];
            r_dinb  <= r_fifo_data[r_rptr[PW-1:0]];
          end
          // Leave on the pop that empties the FIFO unless a push refills it.
          if (w_empty || (w_one && !w_push)) r_state <= ST_IDLE;
`ifdef VRAM_FILL_EN
          r_fill_rej <= bus.fill_start;
`endif
        end

`ifdef VRAM_FILL_EN
        ST_FILL: begin
          r_fill_rej <= bus.fill_start;
          if (r_fill_left != '0) begin
            r_enb       <= 1'b1;
            r_addrb     <= r_fill_addr;
            r_dinb      <= r_fill_data;
            r_fill_addr <= r_fill_addr + ADDR_ONE;
            r_fill_left <= r_fill_left - ADDR_ONE;
          end else begin
            r_fill_done <= 1'b1;
            r_state     <= w_empty ? ST_IDLE : ST_DRAIN;
          end
        end
`endif

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
